scic_core: RTL and testbench

- Parametrised successor to the team's single-accumulator fetch/execute CPU.
- Generalises data and address widths and adds a memory wait-state handshake, SUB/XOR, conditional branches and HALT.
- Sits between the instruction/data memory and the system top level, which observes the halted flag.

---
 rtl/scic_core.sv | 137 +++++++++++++
 tb/tb_scic_core.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scic_core.sv
// Single-accumulator fetch/execute CPU with a parametrised datapath and a memory
// wait-state handshake; memory opcodes stall in EXEC until mem_ready.
module scic_core #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              req,
  output logic              we,
  output logic              halted
);

  typedef logic [DATA_W-1:0] word_t;
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SHL  = 4'h2;
  localparam logic [3:0] OP_SHR  = 4'h3;
  localparam logic [3:0] OP_LDI  = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_AND  = 4'h9;
  localparam logic [3:0] OP_SUB  = 4'hA;
  localparam logic [3:0] OP_XOR  = 4'hB;
  localparam logic [3:0] OP_BZ   = 4'hC;
  localparam logic [3:0] OP_BN   = 4'hD;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam word_t SHIFT_LIMIT = word_t'(DATA_W);

  // IR is kept as its two meaningful fields; the bits between them are never used.
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  word_t             ac_q, ac_d;

  logic  memOp;
  word_t aluResult;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      ac_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      ac_q    <= ac_d;
    end
  end

  always_comb begin
    memOp = 1'b0;
    case (op_q)
      OP_ADD, OP_SHL, OP_SHR, OP_LD, OP_OR,
      OP_ST, OP_AND, OP_SUB, OP_XOR: memOp = 1'b1;
      default:                       memOp = 1'b0;
    endcase
  end

  // Oversized shift amounts clear AC rather than relying on operator semantics.
  always_comb begin
    aluResult = ac_q;
    case (op_q)
      OP_ADD:  aluResult = ac_q + data_in;
      OP_SHL:  aluResult = (data_in >= SHIFT_LIMIT) ? '0 : (ac_q << data_in);
      OP_SHR:  aluResult = (data_in >= SHIFT_LIMIT) ? '0 : (ac_q >> data_in);
      OP_LD:   aluResult = data_in;
      OP_OR:   aluResult = ac_q | data_in;
      OP_AND:  aluResult = ac_q & data_in;
      OP_SUB:  aluResult = ac_q - data_in;
      OP_XOR:  aluResult = ac_q ^ data_in;
      default: aluResult = ac_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    op_d    = op_q;
    addr_d  = addr_q;
    ac_d    = ac_q;
    address = pc_q;
    req     = 1'b0;
    we      = 1'b0;
    halted  = 1'b0;
    case (state_q)
      S_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          op_d    = data_in[DATA_W-1 -: 4];
          addr_d  = data_in[ADDR_W-1:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        address = addr_q;
        if (memOp) begin
          req = 1'b1;
          we  = (op_q == OP_ST);
          if (mem_ready) begin
            ac_d    = aluResult;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_FETCH;
          case (op_q)
            OP_LDI:  ac_d = {{(DATA_W-ADDR_W){1'b0}}, addr_q};
            OP_JMP:  pc_d = addr_q;
            OP_BZ:   if (ac_q == '0) pc_d = addr_q;
            OP_BN:   if (ac_q[DATA_W-1]) pc_d = addr_q;
            OP_HALT: state_d = S_HALT;
            default: ;
          endcase
        end
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  assign data_out = ac_q;

endmodule

// File: tb/tb_scic_core.sv
// Directed bench for scic_core: table of single-op programs plus hand-written
// sequences for stalls, loops, branches, PC wrap and reset corner cases.
module tb_scic_core;

  localparam int DW = 32;
  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic          memReady;
  logic [DW-1:0] dataIn;
  logic [DW-1:0] dataOut;
  logic [AW-1:0] address;
  logic          req;
  logic          we;
  logic          halted;

  logic       reset8;
  logic       memReady8;
  logic [7:0] dataIn8;
  logic [7:0] dataOut8;
  logic [3:0] address8;
  logic       req8;
  logic       we8;
  logic       halted8;

  logic [DW-1:0] mem [0:63];
  logic [7:0]    mem8 [0:15];

  int checks;
  int errors;
  int weCount;
  logic [31:0] lastStAddr;
  logic [31:0] lastStData;
  int unsigned txLog[$];

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] acInit;
    logic [31:0] operand;
    logic [31:0] expAc;
  } vec_t;

  vec_t vecs[$];

  scic_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .data_in(dataIn), .mem_ready(memReady),
    .address(address), .data_out(dataOut), .req(req), .we(we), .halted(halted)
  );

  scic_core #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clock(clock), .reset(reset8), .data_in(dataIn8), .mem_ready(memReady8),
    .address(address8), .data_out(dataOut8), .req(req8), .we(we8), .halted(halted8)
  );

  assign dataIn  = (address < AW'(64)) ? mem[address[5:0]] : '0;
  assign dataIn8 = mem8[address8];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] instr(input logic [3:0] op, input logic [15:0] a);
    return {op, 12'd0, a};
  endfunction

  function automatic vec_t mkVec(input string n, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] e);
    vec_t v;
    v.name = n; v.op = op; v.acInit = a; v.operand = b; v.expAc = e;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Memory side effects are modelled here, just before the edge that commits them.
  task automatic clockCycle();
    if (!reset && req && memReady) begin
      txLog.push_back(32'(address));
      if (we) begin
        mem[address[5:0]] = dataOut;
        lastStAddr = 32'(address);
        lastStData = dataOut;
      end
    end
    if (!reset && req && we) weCount++;
    @(posedge clock);
    #1;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 64; i++) mem[i] = '0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    memReady = 1'b1;
    clockCycle();
    reset = 1'b0;
    weCount = 0;
    txLog.delete();
  endtask

  task automatic runProgram(input int stallStart, input int stallLen, input int maxCycles,
                            input logic [31:0] stallAddr, input logic [31:0] stallAc,
                            output int cycles);
    doReset();
    cycles = 0;
    while (halted !== 1'b1 && cycles < maxCycles) begin
      memReady = !(cycles >= stallStart && cycles < stallStart + stallLen);
      if (!memReady) begin
        checkOutput("stall req", 32'(req), 32'd1);
        checkOutput("stall address", 32'(address), stallAddr);
        checkOutput("stall ac", dataOut, stallAc);
      end
      clockCycle();
      cycles++;
    end
    memReady = 1'b1;
    if (halted !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL halt timeout: got halted=%b expected 1 within %0d cycles", halted, maxCycles);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc;
    clearMem();
    mem[0]  = instr(4'h5, 16'd20);
    mem[1]  = instr(v.op, 16'd21);
    mem[2]  = instr(4'h7, 16'd22);
    mem[3]  = instr(4'hF, 16'd0);
    mem[20] = v.acInit;
    mem[21] = v.operand;
    runProgram(0, 0, 40, 0, 0, cyc);
    checkOutput({v.name, " stored"}, mem[22], v.expAc);
    checkOutput({v.name, " data_out"}, dataOut, v.expAc);
  endtask

  task automatic loadBasicProgram();
    clearMem();
    mem[0]  = instr(4'h4, 16'd5);
    mem[1]  = instr(4'h1, 16'd10);
    mem[2]  = instr(4'h7, 16'd11);
    mem[3]  = instr(4'hF, 16'd0);
    mem[10] = 32'd7;
  endtask

  initial begin
    int cyc;
    int unsigned expLog[$];
    checks = 0;
    errors = 0;
    weCount = 0;
    lastStAddr = '0;
    lastStData = '0;
    reset = 1'b1;
    memReady = 1'b1;
    reset8 = 1'b1;
    memReady8 = 1'b1;
    for (int i = 0; i < 16; i++) mem8[i] = '0;
    clearMem();

    vecs.push_back(mkVec("ADD 5+7",      4'h1, 32'd5,        32'd7,        32'd12));
    vecs.push_back(mkVec("ADD wrap",     4'h1, 32'hFFFFFFFF, 32'd1,        32'd0));
    vecs.push_back(mkVec("SUB 0-1",      4'hA, 32'd0,        32'd1,        32'hFFFFFFFF));
    vecs.push_back(mkVec("SUB 10-3",     4'hA, 32'd10,       32'd3,        32'd7));
    vecs.push_back(mkVec("SHL 3<<4",     4'h2, 32'd3,        32'd4,        32'h30));
    vecs.push_back(mkVec("SHL by 32",    4'h2, 32'd1,        32'd32,       32'd0));
    vecs.push_back(mkVec("SHL by 31",    4'h2, 32'd1,        32'd31,       32'h80000000));
    vecs.push_back(mkVec("SHR by 31",    4'h3, 32'h80000000, 32'd31,       32'd1));
    vecs.push_back(mkVec("SHR by 40",    4'h3, 32'hFFFFFFFF, 32'd40,       32'd0));
    vecs.push_back(mkVec("OR",           4'h6, 32'hF0,       32'h0F,       32'hFF));
    vecs.push_back(mkVec("AND",          4'h9, 32'hF0F0,     32'hFF00,     32'hF000));
    vecs.push_back(mkVec("XOR",          4'hB, 32'hAAAA,     32'hFFFF,     32'h5555));
    vecs.push_back(mkVec("LD",           4'h5, 32'hDEAD,     32'h12345678, 32'h12345678));
    vecs.push_back(mkVec("LDI",          4'h4, 32'hDEAD,     32'd99,       32'h15));
    vecs.push_back(mkVec("NOP",          4'h0, 32'hDEAD,     32'd99,       32'hDEAD));
    vecs.push_back(mkVec("op 1110",      4'hE, 32'hBEEF,     32'd99,       32'hBEEF));
    vecs.push_back(mkVec("BZ not taken", 4'hC, 32'd5,        32'd99,       32'd5));
    vecs.push_back(mkVec("BN not taken", 4'hD, 32'd1,        32'd99,       32'd1));

    // Reset state
    doReset();
    checkOutput("reset address", 32'(address), 32'd0);
    checkOutput("reset req", 32'(req), 32'd1);
    checkOutput("reset we", 32'(we), 32'd0);
    checkOutput("reset data_out", dataOut, 32'd0);
    checkOutput("reset halted", 32'(halted), 32'd0);

    // Basic program, no stalls
    loadBasicProgram();
    runProgram(0, 0, 40, 0, 0, cyc);
    checkOutput("basic cycles", 32'(cyc), 32'd8);
    checkOutput("basic ac", dataOut, 32'd12);
    checkOutput("basic we cycles", 32'(weCount), 32'd1);
    checkOutput("basic st address", lastStAddr, 32'd11);
    checkOutput("basic st data", lastStData, 32'd12);
    for (int i = 0; i < 3; i++) begin
      checkOutput("halt address", 32'(address), 32'd4);
      checkOutput("halt req", 32'(req), 32'd0);
      checkOutput("halt halted", 32'(halted), 32'd1);
      clockCycle();
    end

    // Same program with three wait states on the ADD operand read
    loadBasicProgram();
    runProgram(3, 3, 40, 32'd10, 32'd5, cyc);
    checkOutput("stall cycles", 32'(cyc), 32'd11);
    checkOutput("stall final ac", dataOut, 32'd12);
    checkOutput("stall st data", mem[11], 32'd12);

    // Counting loop: BZ only taken on the third pass
    clearMem();
    mem[0]  = instr(4'h4, 16'd3);
    mem[1]  = instr(4'hA, 16'd30);
    mem[2]  = instr(4'hC, 16'd4);
    mem[3]  = instr(4'h8, 16'd1);
    mem[4]  = instr(4'hF, 16'd0);
    mem[30] = 32'd1;
    runProgram(0, 0, 100, 0, 0, cyc);
    expLog = '{0, 1, 30, 2, 3, 1, 30, 2, 3, 1, 30, 2, 4};
    checkOutput("loop tx count", 32'(txLog.size()), 32'(expLog.size()));
    for (int i = 0; i < expLog.size(); i++)
      checkOutput($sformatf("loop tx %0d", i), (i < txLog.size()) ? txLog[i] : 32'hFFFFFFFF, expLog[i]);
    checkOutput("loop cycles", 32'(cyc), 32'd20);
    checkOutput("loop ac", dataOut, 32'd0);

    // Underflow to all-ones, then BN taken
    clearMem();
    mem[0]  = instr(4'h4, 16'd0);
    mem[1]  = instr(4'hA, 16'd30);
    mem[2]  = instr(4'hD, 16'd6);
    mem[3]  = instr(4'hF, 16'd0);
    mem[6]  = instr(4'h7, 16'd31);
    mem[7]  = instr(4'hF, 16'd0);
    mem[30] = 32'd1;
    runProgram(0, 0, 40, 0, 0, cyc);
    checkOutput("bn stored", mem[31], 32'hFFFFFFFF);
    checkOutput("bn we cycles", 32'(weCount), 32'd1);
    checkOutput("bn cycles", 32'(cyc), 32'd10);

    // Single-op table
    foreach (vecs[i]) applyStimulus(vecs[i]);

    // Narrow instance: 1110 acts as NOP, PC wraps from 15 to 0
    mem8[0]  = 8'h49;
    mem8[1]  = 8'hE3;
    mem8[2]  = 8'h8F;
    mem8[15] = 8'h07;
    reset8 = 1'b1;
    clockCycle();
    reset8 = 1'b0;
    clockCycle();
    clockCycle();
    clockCycle();
    checkOutput("w8 1110 req", 32'(req8), 32'd0);
    checkOutput("w8 1110 ac", 32'(dataOut8), 32'h09);
    clockCycle();
    checkOutput("w8 fetch addr 2", 32'(address8), 32'd2);
    clockCycle();
    clockCycle();
    checkOutput("w8 jmp target", 32'(address8), 32'd15);
    clockCycle();
    checkOutput("w8 nop exec addr", 32'(address8), 32'd7);
    clockCycle();
    checkOutput("w8 wrapped fetch", 32'(address8), 32'd0);
    checkOutput("w8 wrapped req", 32'(req8), 32'd1);

    // Reset while a store is stalled
    clearMem();
    mem[0] = instr(4'h4, 16'd9);
    mem[1] = instr(4'h7, 16'd11);
    mem[2] = instr(4'hF, 16'd0);
    doReset();
    clockCycle();
    clockCycle();
    clockCycle();
    memReady = 1'b0;
    clockCycle();
    checkOutput("st stall we", 32'(we), 32'd1);
    checkOutput("st stall address", 32'(address), 32'd11);
    checkOutput("st stall data_out", dataOut, 32'd9);
    reset = 1'b1;
    clockCycle();
    reset = 1'b0;
    memReady = 1'b1;
    checkOutput("rst st address", 32'(address), 32'd0);
    checkOutput("rst st we", 32'(we), 32'd0);
    checkOutput("rst st req", 32'(req), 32'd1);
    checkOutput("rst st ac", dataOut, 32'd0);
    checkOutput("rst st halted", 32'(halted), 32'd0);

    // Reset out of HALT
    runProgram(0, 0, 40, 0, 0, cyc);
    checkOutput("pre-rst halted", 32'(halted), 32'd1);
    reset = 1'b1;
    clockCycle();
    reset = 1'b0;
    checkOutput("rst halt halted", 32'(halted), 32'd0);
    checkOutput("rst halt address", 32'(address), 32'd0);
    checkOutput("rst halt req", 32'(req), 32'd1);
    checkOutput("rst halt we", 32'(we), 32'd0);
    checkOutput("rst halt ac", dataOut, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
